// File: rtl/tt_dec_pkg.sv
// Shared types, constants and the code-byte decode for the lab2 priority-code decoder.
package tt_dec_pkg;

  localparam int CODE_W = 8;
  localparam int OUT_W = 16;
  localparam int MAX_IDX = 14;
  localparam logic [CODE_W-1:0] CODE_NO_HIT = 8'hF0;

  typedef enum logic {
    CHANGING = 1'b0,
    SETTLED  = 1'b1
  } filt_state_e;

  // Index codes light the enable line plus one request line; F0 lights only enable.
  function automatic logic [OUT_W-1:0] decode(input logic [CODE_W-1:0] code);
    logic [OUT_W-1:0] res;
    res = '0;
    if (code <= CODE_W'(MAX_IDX)) begin
      res[OUT_W-1]    = 1'b1;
      res[code[3:0]]  = 1'b1;
    end else if (code == CODE_NO_HIT) begin
      res[OUT_W-1] = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/tt_dec_stable_filter.sv
// Two-flop resynchroniser plus stability filter; strobes accept_o on the edge a new code settles.
//
// state    | meaning
// CHANGING | candidate still accumulating identical samples
// SETTLED  | candidate held STABLE_CYCLES samples, count saturated
module tt_dec_stable_filter
  import tt_dec_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_i,
  output logic              accept_o,
  output logic [CODE_W-1:0] code_o
);

  localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

  logic [CODE_W-1:0] sync1_q, sync2_q;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CODE_W-1:0] acc_q, acc_d;
  logic [3:0]        cnt_q, cnt_d;
  filt_state_e       state_q, state_d;
  logic              reach;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= 8'hFF;
      acc_q   <= 8'hFF;
      cnt_q   <= '0;
      state_q <= CHANGING;
    end else begin
      sync1_q <= code_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    reach    = 1'b0;
    accept_o = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d  = sync2_q;
      cnt_d   = 4'd1;
      state_d = CHANGING;
      reach   = (STABLE_C == 4'd1);
    end else if (state_q == CHANGING) begin
      cnt_d = cnt_q + 4'd1;
      reach = (cnt_d == STABLE_C);
    end
    // Reaching the threshold only produces a strobe when the code actually differs.
    if (reach) begin
      state_d = SETTLED;
      if (cand_d != acc_q) begin
        acc_d    = cand_d;
        accept_o = 1'b1;
      end
    end
  end

  assign code_o = cand_d;

endmodule

// File: rtl/tt_um_lab2digitallogicq2_dec.sv
// Registered 4-to-16 priority-code decoder for the far end of the lab2 encoder link.
// Optional macro TT_DEC_PULSE_EN: request lines pulse for PULSE_CYCLES after each acceptance.
module tt_um_lab2digitallogicq2_dec
  import tt_dec_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int PULSE_CYCLES  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic              accept;
  logic [CODE_W-1:0] acc_code;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              unused_ok;

  tt_dec_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .code_i  (ui_in),
    .accept_o(accept),
    .code_o  (acc_code)
  );

`ifdef TT_DEC_PULSE_EN
  logic [7:0] pcnt_q, pcnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= '0;
      pcnt_q <= '0;
    end else begin
      out_q  <= out_d;
      pcnt_q <= pcnt_d;
    end
  end

  // A new acceptance restarts the pulse on the new line; enable line stays static.
  always_comb begin
    out_d  = out_q;
    pcnt_d = pcnt_q;
    if (accept) begin
      out_d  = decode(acc_code);
      pcnt_d = 8'(PULSE_CYCLES);
    end else if (pcnt_q != 8'd0) begin
      pcnt_d = pcnt_q - 8'd1;
      if (pcnt_q == 8'd1) out_d[OUT_W-2:0] = '0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  always_comb begin
    out_d = out_q;
    if (accept) out_d = decode(acc_code);
  end
`endif

  assign uo_out    = out_q[15:8];
  assign uio_out   = out_q[7:0];
  assign uio_oe    = 8'hFF;
  assign unused_ok = ^{ena, uio_in};

endmodule
